seed_a_row_prefixer: RTL and testbench

- Sits directly downstream of the seedA storage stage and consumes its 64-bit serialized seedA stream (2 words = 128 bits).
- For each row of matrix A, emits the SHAKE128 absorb input defined by FrodoKEM Gen-A: row index i (16-bit, little-endian) || seedA (16 bytes), 18 bytes in total.
- The output is 3 × 64-bit words per row and feeds the SHAKE padding/absorb stage.
- Stores the seed once per command, then streams rows firstRow .. firstRow+numRows-1.

---
 rtl/seed_a_row_prefixer.sv | 174 +++++++++++++++++
 tb/tb_seed_a_row_prefixer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seed_a_row_prefixer.sv
`default_nettype none
// ============================================================================
//  Module   : seed_a_row_prefixer
//  Purpose  : Builds the FrodoKEM Gen-A SHAKE128 absorb input per matrix-A row
//             (16-bit LE row index || 16-byte seedA) as 3 x 64-bit words.
//  Option   : SEED_A_ROW_PREFIXER_REUSE_SEED_EN enables cmd[32] seed reuse.
//  Revision : 1.0 - initial release
// ============================================================================
module seed_a_row_prefixer #(
    parameter int ROW_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*ROW_W:0]   cmd,
    input  logic               cmd_isReady,
    output logic               cmd_canReceive,
    input  logic [63:0]        in,
    input  logic               in_isReady,
    output logic               in_canReceive,
    output logic               in_isLast,
    output logic [63:0]        out,
    output logic               out_isReady,
    input  logic               out_canReceive,
    output logic               out_isLast,
    output logic               out_isLastRow
);

    localparam logic [1:0]       S_IDLE = 2'd0;
    localparam logic [1:0]       S_LOAD = 2'd1;
    localparam logic [1:0]       S_EMIT = 2'd2;
    localparam logic [ROW_W-1:0] c_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0] c_ZERO = '0;

`ifdef SEED_A_ROW_PREFIXER_REUSE_SEED_EN
    localparam logic c_REUSE_EN = 1'b1;
`else
    localparam logic c_REUSE_EN = 1'b0;
`endif

    logic [1:0]       r_state;
    logic [1:0]       r_ws;
    logic             r_wordCnt;
    logic [ROW_W-1:0] r_rowIdx;
    logic [ROW_W-1:0] r_rowsLeft;
    logic [63:0]      r_seedW0;
    logic [63:0]      r_seedW1;
    logic [63:0]      r_out;
    logic             r_cmdCanReceive;
    logic             r_inCanReceive;
    logic             r_inIsLast;
    logic             r_outIsReady;
    logic             r_outIsLast;
    logic             r_outIsLastRow;

    logic [1:0]       w_stateNext;
    logic [1:0]       w_wsNext;
    logic             w_wordCntNext;
    logic [ROW_W-1:0] w_rowIdxNext;
    logic [ROW_W-1:0] w_rowsLeftNext;
    logic [63:0]      w_seedW0Next;
    logic [63:0]      w_seedW1Next;
    logic [63:0]      w_outNext;
    logic             w_reuse;

    assign w_reuse = cmd[2*ROW_W] & c_REUSE_EN;

    always_comb begin
        w_stateNext    = r_state;
        w_wsNext       = r_ws;
        w_wordCntNext  = r_wordCnt;
        w_rowIdxNext   = r_rowIdx;
        w_rowsLeftNext = r_rowsLeft;
        w_seedW0Next   = r_seedW0;
        w_seedW1Next   = r_seedW1;
        case (r_state)
            S_IDLE: begin
                if (cmd_isReady && r_cmdCanReceive) begin
                    w_rowIdxNext   = cmd[2*ROW_W-1:ROW_W];
                    w_rowsLeftNext = cmd[ROW_W-1:0];
                    w_wsNext       = 2'd0;
                    w_wordCntNext  = 1'b0;
                    if (!w_reuse)
                        w_stateNext = S_LOAD;
                    else if (cmd[ROW_W-1:0] != c_ZERO)
                        w_stateNext = S_EMIT;
                end
            end
            S_LOAD: begin
                if (in_isReady && r_inCanReceive) begin
                    if (!r_wordCnt) begin
                        w_seedW0Next  = in;
                        w_wordCntNext = 1'b1;
                    end else begin
                        w_seedW1Next  = in;
                        w_wordCntNext = 1'b0;
                        w_stateNext   = (r_rowsLeft == c_ZERO) ? S_IDLE : S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (out_canReceive && r_outIsReady) begin
                    if (r_ws == 2'd2) begin
                        w_wsNext       = 2'd0;
                        w_rowIdxNext   = r_rowIdx + c_ONE;
                        w_rowsLeftNext = r_rowsLeft - c_ONE;
                        if (r_rowsLeft == c_ONE)
                            w_stateNext = S_IDLE;
                    end else begin
                        w_wsNext = r_ws + 2'd1;
                    end
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Output word is formed from next-cycle values so it lands in a flop.
    always_comb begin
        w_outNext = '0;
        case (w_wsNext)
            2'd0:    w_outNext = {w_seedW0Next[63-ROW_W:0], w_rowIdxNext};
            2'd1:    w_outNext = {w_seedW1Next[63-ROW_W:0], w_seedW0Next[63:64-ROW_W]};
            default: w_outNext = {{(64-ROW_W){1'b0}}, w_seedW1Next[63:64-ROW_W]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_ws            <= 2'd0;
            r_wordCnt       <= 1'b0;
            r_rowIdx        <= '0;
            r_rowsLeft      <= '0;
            r_cmdCanReceive <= 1'b1;
            r_inCanReceive  <= 1'b0;
            r_inIsLast      <= 1'b0;
            r_outIsReady    <= 1'b0;
            r_outIsLast     <= 1'b0;
            r_outIsLastRow  <= 1'b0;
        end else begin
            r_state         <= w_stateNext;
            r_ws            <= w_wsNext;
            r_wordCnt       <= w_wordCntNext;
            r_rowIdx        <= w_rowIdxNext;
            r_rowsLeft      <= w_rowsLeftNext;
            r_cmdCanReceive <= (w_stateNext == S_IDLE);
            r_inCanReceive  <= (w_stateNext == S_LOAD);
            r_inIsLast      <= (w_stateNext == S_LOAD) && w_wordCntNext;
            r_outIsReady    <= (w_stateNext == S_EMIT);
            r_outIsLast     <= (w_stateNext == S_EMIT) && (w_wsNext == 2'd2);
            r_outIsLastRow  <= (w_stateNext == S_EMIT) && (w_wsNext == 2'd2)
                               && (w_rowsLeftNext == c_ONE);
        end
    end

    // Seed and output data carry no reset; the seed survives a mid-command reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seedW0 <= w_seedW0Next;
            r_seedW1 <= w_seedW1Next;
        end
        r_out <= w_outNext;
    end

    assign cmd_canReceive = r_cmdCanReceive;
    assign in_canReceive  = r_inCanReceive;
    assign in_isLast      = r_inIsLast;
    assign out            = r_out;
    assign out_isReady    = r_outIsReady;
    assign out_isLast     = r_outIsLast;
    assign out_isLastRow  = r_outIsLastRow;

endmodule
`default_nettype wire

// File: tb/tb_seed_a_row_prefixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seed_a_row_prefixer
//  Purpose  : Directed self-checking bench for seed_a_row_prefixer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seed_a_row_prefixer;

    localparam logic [63:0] c_S0 = 64'h0706050403020100;
    localparam logic [63:0] c_S1 = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] c_N0 = 64'h1716151413121110;
    localparam logic [63:0] c_N1 = 64'h1F1E1D1C1B1A1918;
    localparam logic [63:0] c_W1 = 64'h0D0C0B0A09080706;
    localparam logic [63:0] c_W2 = 64'h0000000000000F0E;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] cmd;
    logic        cmd_isReady;
    logic        cmd_canReceive;
    logic [63:0] tbIn;
    logic        in_isReady;
    logic        in_canReceive;
    logic        in_isLast;
    logic [63:0] tbOut;
    logic        out_isReady;
    logic        out_canReceive;
    logic        out_isLast;
    logic        out_isLastRow;

    int vectors     = 0;
    int miscompares = 0;
    logic [65:0] outQ[$];

    always #5 clk = ~clk;

    seed_a_row_prefixer dut (
        .clk            (clk),
        .rst            (rst),
        .cmd            (cmd),
        .cmd_isReady    (cmd_isReady),
        .cmd_canReceive (cmd_canReceive),
        .in             (tbIn),
        .in_isReady     (in_isReady),
        .in_canReceive  (in_canReceive),
        .in_isLast      (in_isLast),
        .out            (tbOut),
        .out_isReady    (out_isReady),
        .out_canReceive (out_canReceive),
        .out_isLast     (out_isLast),
        .out_isLastRow  (out_isLastRow)
    );

    // Record every output transfer that the next rising edge will perform.
    always @(negedge clk)
        if (rst && out_isReady && out_canReceive)
            outQ.push_back({out_isLast, out_isLastRow, tbOut});

    task automatic checkValue(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic reuse, input logic [15:0] first, input logic [15:0] num);
        bit done = 0;
        cmd = {reuse, first, num};
        cmd_isReady = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (cmd_canReceive) done = 1;
            tick();
        end
        cmd_isReady = 1'b0;
        if (!done) checkValue("cmdTimeout", 1, 0);
    endtask

    task automatic sendSeed(input logic [63:0] w0, input logic [63:0] w1);
        for (int k = 0; k < 2; k++) begin
            bit done = 0;
            tbIn = (k == 0) ? w0 : w1;
            in_isReady = 1'b1;
            for (int i = 0; i < 50 && !done; i++) begin
                if (in_canReceive) done = 1;
                else tick();
            end
            if (!done) checkValue("seedTimeout", 1, 0);
            checkValue((k == 0) ? "inIsLastW0" : "inIsLastW1", in_isLast, k);
            tick();
        end
        in_isReady = 1'b0;
    endtask

    task automatic waitIdle(input int bound, output int cycles);
        cycles = 0;
        while (!cmd_canReceive && cycles < bound) begin
            tick();
            cycles++;
        end
        if (!cmd_canReceive) checkValue("idleTimeout", 1, 0);
    endtask

    task automatic checkWord(input string tag, input int idx, input logic [65:0] exp);
        if (idx >= outQ.size()) checkValue(tag, outQ.size(), idx + 1);
        else                    checkValue(tag, outQ[idx], exp);
    endtask

    task automatic checkTwoRowRun(input string tag, input logic [15:0] r0, input logic [15:0] r1);
        checkValue({tag, "Count"}, outQ.size(), 6);
        checkWord({tag, "R0W0"}, 0, {2'b00, c_S0[47:0], r0});
        checkWord({tag, "R0W1"}, 1, {2'b00, c_W1});
        checkWord({tag, "R0W2"}, 2, {2'b10, c_W2});
        checkWord({tag, "R1W0"}, 3, {2'b00, c_S0[47:0], r1});
        checkWord({tag, "R1W1"}, 4, {2'b00, c_W1});
        checkWord({tag, "R1W2"}, 5, {2'b11, c_W2});
    endtask

    initial begin
        int cyc;
        int lastCnt;
        int lastRowCnt;
        logic [63:0] held;
        rst = 1'b0; cmd = '0; cmd_isReady = 1'b0; tbIn = '0; in_isReady = 1'b0;
        out_canReceive = 1'b0;
        repeat (3) tick();
        checkValue("rstCmdCanRx",  cmd_canReceive, 1);
        checkValue("rstOutReady",  out_isReady, 0);
        checkValue("rstInCanRx",   in_canReceive, 0);
        checkValue("rstOutLast",   out_isLast, 0);
        checkValue("rstOutLastRow", out_isLastRow, 0);
        rst = 1'b1;
        tick();

        // Basic two-row command
        out_canReceive = 1'b1;
        sendCmd(1'b0, 16'h0000, 16'd2);
        sendSeed(c_S0, c_S1);
        checkValue("firstWordLatency", out_isReady, 1);
        waitIdle(100, cyc);
        checkTwoRowRun("basic", 16'h0000, 16'h0001);
        checkValue("basicIdle", cmd_canReceive, 1);
        outQ.delete();

        // Row index wrap
        sendCmd(1'b0, 16'hFFFF, 16'd2);
        sendSeed(c_S0, c_S1);
        waitIdle(100, cyc);
        checkTwoRowRun("wrap", 16'hFFFF, 16'h0000);
        outQ.delete();

        // Back-pressure 1,0,0,1
        out_canReceive = 1'b0;
        sendCmd(1'b0, 16'h0000, 16'd2);
        sendSeed(c_S0, c_S1);
        out_canReceive = 1'b1; tick();
        out_canReceive = 1'b0; held = tbOut; tick();
        checkValue("stallHoldData", tbOut, held);
        checkValue("stallHoldWord1", tbOut, c_W1);
        checkValue("stallHoldReady", out_isReady, 1);
        tick();
        out_canReceive = 1'b1;
        waitIdle(100, cyc);
        checkTwoRowRun("stall", 16'h0000, 16'h0001);
        outQ.delete();

        // Zero rows: seed consumed, nothing emitted
        sendCmd(1'b0, 16'h0010, 16'd0);
        sendSeed(c_S0, c_S1);
        checkValue("zeroRowsIdle", cmd_canReceive, 1);
        checkValue("zeroRowsReady", out_isReady, 0);
        repeat (3) tick();
        checkValue("zeroRowsCount", outQ.size(), 0);

        // Reset in the middle of a row, after word1
        out_canReceive = 1'b0;
        sendCmd(1'b0, 16'h0000, 16'd1);
        sendSeed(c_S0, c_S1);
        out_canReceive = 1'b1;
        repeat (2) tick();
        out_canReceive = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkValue("midRstReady", out_isReady, 0);
        checkValue("midRstCmdCanRx", cmd_canReceive, 1);
        outQ.delete();
        sendCmd(1'b1, 16'h0005, 16'd1);
`ifdef SEED_A_ROW_PREFIXER_REUSE_SEED_EN
        checkValue("reuseReady", out_isReady, 1);
        checkValue("reuseWord0", tbOut, {c_S0[47:0], 16'h0005});
`else
        checkValue("noReuseLoad", in_canReceive, 1);
        checkValue("noReuseReady", out_isReady, 0);
        sendSeed(c_N0, c_N1);
        checkValue("noReuseWord0", tbOut, {c_N0[47:0], 16'h0005});
`endif
        out_canReceive = 1'b1;
        waitIdle(100, cyc);
        checkValue("afterRstCount", outQ.size(), 3);
        outQ.delete();

        // Long continuous command
        sendCmd(1'b0, 16'h0000, 16'd640);
        sendSeed(c_S0, c_S1);
        waitIdle(5000, cyc);
        checkValue("longCycles", cyc, 1920);
        checkValue("longCount", outQ.size(), 1920);
        lastCnt = 0;
        lastRowCnt = 0;
        foreach (outQ[i]) begin
            lastCnt    += int'(outQ[i][65]);
            lastRowCnt += int'(outQ[i][64]);
        end
        checkValue("longLastPulses", lastCnt, 640);
        checkValue("longLastRowPulses", lastRowCnt, 1);
        checkWord("longFinalRowW0", 1917, {2'b00, c_S0[47:0], 16'h027F});
        checkWord("longFinalW2", 1919, {2'b11, c_W2});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
